stream_mux_4_1: RTL and testbench

- Four-input, one-output streaming multiplexer with valid/ready handshakes on every port.
- Merges four independent producer channels onto one registered output stream.
- Arbitrates with a fair round-robin policy.
- Tags each output word with its source channel index (Select_Out) so a downstream 1:4 demultiplexer can route words back by channel.

---
 rtl/stream_mux_4_1.sv | 89 ++++++++
 tb/tb_stream_mux_4_1.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_4_1.sv
// Four-to-one valid/ready stream mux with round-robin arbitration and a single registered output stage.
// One cycle latency from accept to Valid_Out; sustains one word per cycle when Ready_In stays high.
module stream_mux_4_1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_0_In,
  input  logic [DATA_WIDTH-1:0] Data_1_In,
  input  logic [DATA_WIDTH-1:0] Data_2_In,
  input  logic [DATA_WIDTH-1:0] Data_3_In,
  input  logic                  Valid_0_In,
  input  logic                  Valid_1_In,
  input  logic                  Valid_2_In,
  input  logic                  Valid_3_In,
  output logic                  Ready_0_Out,
  output logic                  Ready_1_Out,
  output logic                  Ready_2_Out,
  output logic                  Ready_3_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  input  logic                  Ready_In,
  output logic [1:0]            Select_Out
);

  logic [DATA_WIDTH-1:0] data_arr [4];
  logic [3:0]            valid_vec;
  logic [3:0]            grant;
  logic [3:0]            ready_vec;
  logic [1:0]            ptr;
  logic [1:0]            winner;
  logic [1:0]            idx;
  logic                  win_vld;
  logic                  space;
  logic                  accept;
  logic                  xfer;

  assign data_arr[0] = Data_0_In;
  assign data_arr[1] = Data_1_In;
  assign data_arr[2] = Data_2_In;
  assign data_arr[3] = Data_3_In;
  assign valid_vec   = {Valid_3_In, Valid_2_In, Valid_1_In, Valid_0_In};

  assign space = ~Valid_Out | Ready_In;
  assign xfer  = Valid_Out & Ready_In;

  // Scan ptr, ptr+1, ... with natural 2-bit wrap; first valid channel wins.
  always_comb begin
    grant   = '0;
    winner  = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!win_vld && valid_vec[idx]) begin
        win_vld = 1'b1;
        winner  = idx;
      end
    end
    if (win_vld) grant[winner] = 1'b1;
  end

  // Reset gates the readies so no producer sees an accept while the block is held.
  assign ready_vec = {4{Enable_In & space & Reset_N_In}} & grant;
  assign accept    = Enable_In & space & win_vld & Reset_N_In;

  assign Ready_0_Out = ready_vec[0];
  assign Ready_1_Out = ready_vec[1];
  assign Ready_2_Out = ready_vec[2];
  assign Ready_3_Out = ready_vec[3];

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      Data_Out   <= '0;
      Select_Out <= 2'd0;
      Valid_Out  <= 1'b0;
      ptr        <= 2'd0;
    end else if (accept) begin
      Data_Out   <= data_arr[winner];
      Select_Out <= winner;
      Valid_Out  <= 1'b1;
      ptr        <= winner + 2'd1;
    end else if (xfer) begin
      Valid_Out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_4_1.sv
// Bench for stream_mux_4_1: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_stream_mux_4_1;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         rdy_in = 1'b0;
  logic [W-1:0] d [4];
  logic [3:0]   v = 4'b0;
  logic [3:0]   rdy;
  logic [W-1:0] dout;
  logic         vout;
  logic [1:0]   sel;

  int total = 0;
  int bad = 0;

  // Reference state: round-robin pointer plus the one-entry output register.
  int           m_ptr = 0;
  bit           m_vld = 1'b0;
  logic [W-1:0] m_dat = '0;
  int           m_sel = 0;
  logic [3:0]   last_acc = 4'b0;

  always #5 clk = ~clk;

  stream_mux_4_1 #(.DATA_WIDTH(W)) dut (
    .Clock_In   (clk),
    .Reset_N_In (rst_n),
    .Enable_In  (en),
    .Data_0_In  (d[0]),
    .Data_1_In  (d[1]),
    .Data_2_In  (d[2]),
    .Data_3_In  (d[3]),
    .Valid_0_In (v[0]),
    .Valid_1_In (v[1]),
    .Valid_2_In (v[2]),
    .Valid_3_In (v[3]),
    .Ready_0_Out(rdy[0]),
    .Ready_1_Out(rdy[1]),
    .Ready_2_Out(rdy[2]),
    .Ready_3_Out(rdy[3]),
    .Data_Out   (dout),
    .Valid_Out  (vout),
    .Ready_In   (rdy_in),
    .Select_Out (sel)
  );

  function automatic logic [3:0] exp_ready();
    int k;
    if (!rst_n || !en || (m_vld && !rdy_in)) return 4'b0;
    for (int i = 0; i < 4; i++) begin
      k = (m_ptr + i) % 4;
      if (v[k]) return 4'(1 << k);
    end
    return 4'b0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_vld = 1'b0; m_dat = '0; m_sel = 0;
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic tick();
    logic [3:0] acc;
    acc = exp_ready() & v;
    @(posedge clk); #1;
    last_acc = acc;
    if (acc != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) begin
          m_vld = 1'b1; m_dat = d[k]; m_sel = k; m_ptr = (k + 1) % 4;
        end
      end
    end else if (m_vld && rdy_in) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; rdy_in = 1'b1; v = 4'b0;
    for (int k = 0; k < 4; k++) d[k] = 8'hEE;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL reset_vout got=%b exp=0", vout); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    v = 4'hF; #1;
    total++; if (rdy !== 4'b0) begin bad++; $display("FAIL reset_ready_held got=%b exp=0000", rdy); end
    v = 4'b0; rst_n = 1'b1;
    tick();
    total++; if (vout !== 1'b0 || dout !== 8'h00 || sel !== 2'd0 || rdy !== 4'b0) begin
      bad++; $display("FAIL reset_release_idle vout=%b dout=%h sel=%0d rdy=%b exp 0/00/0/0000", vout, dout, sel, rdy);
    end
  endtask

  task automatic test_single_stream();
    rdy_in = 1'b1; en = 1'b1; v = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      d[2] = 8'(8'h10 + i); #1;
      total++; if (rdy !== 4'b0100) begin bad++; $display("FAIL single_ready[%0d] got=%b exp=0100", i, rdy); end
      tick();
      total++; if (vout !== 1'b1 || dout !== 8'(8'h10 + i) || sel !== 2'd2) begin
        bad++; $display("FAIL single_out[%0d] vout=%b dout=%h sel=%0d exp 1/%h/2", i, vout, dout, sel, 8'(8'h10 + i));
      end
    end
    v = 4'b0;
    tick();
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", vout); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] cdat [4];
    cdat[0] = 8'hA0; cdat[1] = 8'hB1; cdat[2] = 8'hC2; cdat[3] = 8'hD3;
    #1 rst_n = 1'b0; #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) d[k] = cdat[k];
    v = 4'hF; rdy_in = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if ($countones(rdy) != 1 || rdy !== 4'(1 << (i % 4))) begin
        bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, rdy, 4'(1 << (i % 4)));
      end
      tick();
      total++; if (sel !== 2'(i % 4) || dout !== cdat[i % 4] || vout !== 1'b1) begin
        bad++; $display("FAIL rr_out[%0d] sel=%0d dout=%h vout=%b exp %0d/%h/1", i, sel, dout, vout, i % 4, cdat[i % 4]);
      end
    end
  endtask

  task automatic test_backpressure();
    v = 4'b0; tick();
    d[1] = 8'h55; v = 4'b0010; tick();
    for (int k = 0; k < 4; k++) d[k] = 8'(8'h60 + k);
    v = 4'hF; rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (rdy !== 4'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, rdy); end
      tick();
      total++; if (dout !== 8'h55 || vout !== 1'b1 || sel !== 2'd1) begin
        bad++; $display("FAIL bp_hold[%0d] dout=%h vout=%b sel=%0d exp 55/1/1", i, dout, vout, sel);
      end
    end
    rdy_in = 1'b1; #1;
    total++; if (rdy !== 4'b0100) begin bad++; $display("FAIL bp_resume_ready got=%b exp=0100", rdy); end
    tick();
    total++; if (dout !== 8'h62 || sel !== 2'd2 || vout !== 1'b1) begin
      bad++; $display("FAIL bp_resume_out dout=%h sel=%0d vout=%b exp 62/2/1", dout, sel, vout);
    end
  endtask

  task automatic test_enable();
    v = 4'b0; tick();
    d[3] = 8'h77; v = 4'b1000; tick();
    en = 1'b0; v = 4'hF; rdy_in = 1'b0; #1;
    total++; if (rdy !== 4'b0) begin bad++; $display("FAIL en_ready_stall got=%b exp=0000", rdy); end
    tick();
    total++; if (dout !== 8'h77 || vout !== 1'b1) begin bad++; $display("FAIL en_hold dout=%h vout=%b exp 77/1", dout, vout); end
    rdy_in = 1'b1; #1;
    total++; if (rdy !== 4'b0) begin bad++; $display("FAIL en_ready_drain got=%b exp=0000", rdy); end
    tick();
    total++; if (vout !== 1'b0 || dout !== 8'h77) begin bad++; $display("FAIL en_drained vout=%b dout=%h exp 0/77", vout, dout); end
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (rdy !== 4'b0) begin bad++; $display("FAIL en_idle_ready[%0d] got=%b exp=0000", i, rdy); end
      tick();
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL en_idle_vout[%0d] got=%b exp=0", i, vout); end
    end
    en = 1'b1; #1;
    total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL en_restore_ready got=%b exp=0001", rdy); end
    tick();
    total++; if (sel !== 2'd0 || dout !== 8'h60 || vout !== 1'b1) begin
      bad++; $display("FAIL en_restore_out sel=%0d dout=%h vout=%b exp 0/60/1", sel, dout, vout);
    end
  endtask

  task automatic test_async_reset();
    v = 4'b0100; tick();
    v = 4'b0;
    total++; if (vout !== 1'b1) begin bad++; $display("FAIL ar_preload vout=%b exp=1", vout); end
    #2 rst_n = 1'b0; #1;
    total++; if (vout !== 1'b0 || dout !== 8'h00 || sel !== 2'd0) begin
      bad++; $display("FAIL ar_immediate vout=%b dout=%h sel=%0d exp 0/00/0", vout, dout, sel);
    end
    model_reset();
    #1 rst_n = 1'b1;
    v = 4'hF; rdy_in = 1'b1; en = 1'b1; #1;
    total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL ar_restart_ready got=%b exp=0001", rdy); end
    tick();
    total++; if (sel !== 2'd0 || dout !== d[0]) begin bad++; $display("FAIL ar_restart_out sel=%0d dout=%h exp 0/%h", sel, dout, d[0]); end
  endtask

  task automatic test_random();
    int wait_cnt [4];
    int max_wait;
    max_wait = 0;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    v = 4'b0;
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!v[k] && ($urandom % 2 == 0)) begin
          v[k] = 1'b1; d[k] = 8'($urandom);
        end
      end
      en = ($urandom % 8) != 0;
      rdy_in = ($urandom % 4) != 0;
      #1;
      total++; if (rdy !== exp_ready() || $countones(rdy) > 1) begin
        bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, rdy, exp_ready());
      end
      tick();
      total++; if (vout !== m_vld || (m_vld && (dout !== m_dat || sel !== 2'(m_sel)))) begin
        bad++; $display("FAIL rand_out[%0d] vout=%b dout=%h sel=%0d exp %b/%h/%0d", c, vout, dout, sel, m_vld, m_dat, m_sel);
      end
      for (int k = 0; k < 4; k++) begin
        if (last_acc[k]) begin
          v[k] = 1'b0; wait_cnt[k] = 0;
        end else if (v[k] && last_acc != 4'b0) begin
          wait_cnt[k]++;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end
      end
    end
    total++; if (max_wait > 3) begin bad++; $display("FAIL rand_fairness max_wait=%0d exp<=3", max_wait); end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
